// File: rtl/vita_sync_pkg.sv
// Shared constants, types and helpers for the VITA2000 sync-lane capture sequencer.
// Code values here are the defaults; the top exposes them as overridable parameters.
package vita_sync_pkg;

  localparam logic [15:0] DEF_TR_CODE  = 16'h3A6C;
  localparam logic [15:0] DEF_FS_CODE  = 16'hAA00;
  localparam logic [15:0] DEF_LS_CODE  = 16'hA500;
  localparam logic [15:0] DEF_IMG_CODE = 16'h3500;
  localparam logic [15:0] DEF_LE_CODE  = 16'hA600;
  localparam logic [15:0] DEF_FE_CODE  = 16'hAB00;

  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_MAX_LINES  = 1088;

  localparam int KERNEL_CYCLES = 16;
  localparam int PHASE_W       = 4;
  localparam int KIDX_W        = 8;
  localparam int LIDX_W        = 11;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(KERNEL_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2,
    IN_FRAME = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_TR   = 3'd1,
    C_FS   = 3'd2,
    C_LS   = 3'd3,
    C_IMG  = 3'd4,
    C_LE   = 3'd5,
    C_FE   = 3'd6
  } code_t;

  function automatic logic [KIDX_W-1:0] sat_inc(input logic [KIDX_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vita_word_aligner.sv
// Sync-lane deserializer: finds the training word, establishes the kernel phase
// and reports lock; the frame sequencer can drop lock through `lost`.
module vita_word_aligner
  import vita_sync_pkg::*;
#(
  parameter logic [15:0] TR_CODE    = DEF_TR_CODE,
  parameter int          LOCK_COUNT = DEF_LOCK_COUNT
) (
  input  logic        pclock,
  input  logic        reset,
  input  logic        sync_bit,
  input  logic        lost,
  output logic [15:0] word,
  output logic        boundary,
  output logic        pre_boundary,
  output logic        locked
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

  logic [14:0]        sr_reg;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic [3:0]         tr_cnt_reg, tr_cnt_next;
  state_t             align_reg, align_next;
  logic               locked_reg;

  assign word         = {sr_reg, sync_bit};
  assign boundary     = (align_reg != HUNT) && (phase_reg == PHASE_LAST);
  assign pre_boundary = (align_reg != HUNT) && (phase_reg == PHASE_LAST - 1'b1);
  assign locked       = locked_reg;

  always_comb begin
    align_next  = align_reg;
    phase_next  = phase_reg + 1'b1;
    tr_cnt_next = tr_cnt_reg;
    if (lost) begin
      align_next  = HUNT;
      tr_cnt_next = '0;
    end else begin
      case (align_reg)
        HUNT: begin
          // The cycle that completes a TR word acts as the first boundary.
          if (word == TR_CODE) begin
            phase_next  = '0;
            tr_cnt_next = 4'd1;
            align_next  = LOCKING;
          end
        end
        LOCKING: begin
          if (phase_reg == PHASE_LAST) begin
            if (word == TR_CODE) begin
              tr_cnt_next = tr_cnt_reg + 1'b1;
              if (tr_cnt_next >= LOCK_TARGET) align_next = LOCKED;
            end else begin
              tr_cnt_next = '0;
              align_next  = HUNT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      sr_reg     <= '0;
      phase_reg  <= '0;
      tr_cnt_reg <= '0;
      align_reg  <= HUNT;
      locked_reg <= 1'b0;
    end else begin
      sr_reg     <= word[14:0];
      phase_reg  <= phase_next;
      tr_cnt_reg <= tr_cnt_next;
      align_reg  <= align_next;
      locked_reg <= (align_next == LOCKED);
    end
  end

endmodule

// File: rtl/vita_capture_ctrl.sv
// Frame sequencer for the VITA2000 capture path: decodes one sync code per kernel
// and produces registered record/clear controls plus kernel/line/frame strobes.
module vita_capture_ctrl
  import vita_sync_pkg::*;
#(
  parameter logic [15:0] TR_CODE    = DEF_TR_CODE,
  parameter logic [15:0] FS_CODE    = DEF_FS_CODE,
  parameter logic [15:0] LS_CODE    = DEF_LS_CODE,
  parameter logic [15:0] IMG_CODE   = DEF_IMG_CODE,
  parameter logic [15:0] LE_CODE    = DEF_LE_CODE,
  parameter logic [15:0] FE_CODE    = DEF_FE_CODE,
  parameter int          LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int          MAX_LINES  = DEF_MAX_LINES
) (
  input  logic              pclock,
  input  logic              reset,
  input  logic              sync_bit,
  input  logic              arm,
  output logic              record,
  output logic              capture_clr,
  output logic              kernel_valid,
  output logic              line_start,
  output logic              line_end,
  output logic              frame_start,
  output logic              frame_end,
  output logic [KIDX_W-1:0] kernel_index,
  output logic [LIDX_W-1:0] line_index,
  output logic              locked,
  output logic              sync_err
);

  localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(MAX_LINES - 1);

  logic [15:0] word;
  logic        boundary, pre_boundary, aligned, lost;
  code_t       code;

  state_t            state_reg, state_next;
  logic              arm_latch_reg, arm_latch_next;
  logic              in_line_reg, in_line_next;
  logic              record_reg, record_next;
  logic              clr_reg, clr_next;
  logic              kv_reg, kv_next;
  logic              ls_reg, ls_next;
  logic              le_reg, le_next;
  logic              fs_reg, fs_next;
  logic              fe_reg, fe_next;
  logic              err_reg, err_next;
  logic              line_inc_reg, line_inc_next;
  logic [KIDX_W-1:0] kernel_index_reg, kernel_index_next;
  logic [LIDX_W-1:0] line_index_reg, line_index_next;
  logic              do_start, do_abort;

  vita_word_aligner #(
    .TR_CODE    (TR_CODE),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_aligner (
    .pclock       (pclock),
    .reset        (reset),
    .sync_bit     (sync_bit),
    .lost         (lost),
    .word         (word),
    .boundary     (boundary),
    .pre_boundary (pre_boundary),
    .locked       (aligned)
  );

  always_comb begin
    code = C_NONE;
    if      (word == TR_CODE)  code = C_TR;
    else if (word == FS_CODE)  code = C_FS;
    else if (word == LS_CODE)  code = C_LS;
    else if (word == IMG_CODE) code = C_IMG;
    else if (word == LE_CODE)  code = C_LE;
    else if (word == FE_CODE)  code = C_FE;
  end

  always_comb begin
    state_next        = state_reg;
    arm_latch_next    = arm_latch_reg | arm;
    in_line_next      = in_line_reg;
    record_next       = record_reg;
    kernel_index_next = kernel_index_reg;
    line_index_next   = line_inc_reg ? line_index_reg + 1'b1 : line_index_reg;
    line_inc_next     = 1'b0;
    // Registered one cycle early so the clear lands on the boundary cycle itself.
    clr_next          = pre_boundary && (state_reg != IN_FRAME);
    kv_next           = 1'b0;
    ls_next           = 1'b0;
    le_next           = 1'b0;
    fs_next           = 1'b0;
    fe_next           = 1'b0;
    err_next          = 1'b0;
    do_start          = 1'b0;
    do_abort          = 1'b0;
    lost              = 1'b0;

    case (state_reg)
      HUNT: begin
        record_next  = 1'b0;
        in_line_next = 1'b0;
        if (aligned) state_next = LOCKED;
      end
      LOCKED: begin
        if (boundary) begin
          if (code == C_NONE) do_abort = 1'b1;
          else if (code == C_FS && (arm_latch_reg || arm)) do_start = 1'b1;
        end
      end
      IN_FRAME: begin
        if (boundary) begin
          case (code)
            C_FS: begin
              err_next = 1'b1;
              do_start = 1'b1;
            end
            C_LS: begin
              kv_next           = 1'b1;
              ls_next           = 1'b1;
              kernel_index_next = '0;
              in_line_next      = 1'b1;
            end
            C_IMG: begin
              if (in_line_reg) begin
                kv_next           = 1'b1;
                kernel_index_next = sat_inc(kernel_index_reg);
              end else begin
                err_next = 1'b1;
              end
            end
            C_LE: begin
              if (in_line_reg) begin
                kv_next           = 1'b1;
                le_next           = 1'b1;
                kernel_index_next = sat_inc(kernel_index_reg);
                // line_index stays put while the LE kernel is qualified.
                line_inc_next     = 1'b1;
                in_line_next      = 1'b0;
                if (line_index_reg == LAST_LINE) begin
                  fe_next     = 1'b1;
                  err_next    = 1'b1;
                  record_next = 1'b0;
                  state_next  = LOCKED;
                end
              end else begin
                err_next = 1'b1;
              end
            end
            C_FE: begin
              fe_next      = 1'b1;
              record_next  = 1'b0;
              in_line_next = 1'b0;
              state_next   = LOCKED;
            end
            C_TR: ;
            default: do_abort = 1'b1;
          endcase
        end
      end
      default: state_next = HUNT;
    endcase

    if (do_start) begin
      fs_next         = 1'b1;
      record_next     = 1'b1;
      line_index_next = '0;
      line_inc_next   = 1'b0;
      arm_latch_next  = 1'b0;
      in_line_next    = 1'b0;
      state_next      = IN_FRAME;
    end
    if (do_abort) begin
      err_next     = 1'b1;
      lost         = 1'b1;
      record_next  = 1'b0;
      in_line_next = 1'b0;
      state_next   = HUNT;
    end
  end

  always_ff @(posedge pclock) begin
    if (reset) begin
      state_reg        <= HUNT;
      arm_latch_reg    <= 1'b0;
      in_line_reg      <= 1'b0;
      record_reg       <= 1'b0;
      clr_reg          <= 1'b0;
      kv_reg           <= 1'b0;
      ls_reg           <= 1'b0;
      le_reg           <= 1'b0;
      fs_reg           <= 1'b0;
      fe_reg           <= 1'b0;
      err_reg          <= 1'b0;
      line_inc_reg     <= 1'b0;
      kernel_index_reg <= '0;
      line_index_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      arm_latch_reg    <= arm_latch_next;
      in_line_reg      <= in_line_next;
      record_reg       <= record_next;
      clr_reg          <= clr_next;
      kv_reg           <= kv_next;
      ls_reg           <= ls_next;
      le_reg           <= le_next;
      fs_reg           <= fs_next;
      fe_reg           <= fe_next;
      err_reg          <= err_next;
      line_inc_reg     <= line_inc_next;
      kernel_index_reg <= kernel_index_next;
      line_index_reg   <= line_index_next;
    end
  end

  assign record       = record_reg;
  assign capture_clr  = clr_reg;
  assign kernel_valid = kv_reg;
  assign line_start   = ls_reg;
  assign line_end     = le_reg;
  assign frame_start  = fs_reg;
  assign frame_end    = fe_reg;
  assign kernel_index = kernel_index_reg;
  assign line_index   = line_index_reg;
  assign locked       = aligned;
  assign sync_err     = err_reg;

endmodule

// File: tb/tb_vita_capture_ctrl.sv
// Directed bench for vita_capture_ctrl: streams sync words bit-serially and checks
// the strobes seen in the cycle after each word boundary (MAX_LINES forced to 2).
module tb_vita_capture_ctrl;

  localparam logic [15:0] TR  = 16'h3A6C;
  localparam logic [15:0] FS  = 16'hAA00;
  localparam logic [15:0] LS  = 16'hA500;
  localparam logic [15:0] IMG = 16'h3500;
  localparam logic [15:0] LE  = 16'hA600;
  localparam logic [15:0] FE  = 16'hAB00;
  localparam logic [15:0] BAD = 16'h1234;

  logic        pclock = 1'b0;
  logic        reset = 1'b1;
  logic        sync_bit = 1'b0;
  logic        arm = 1'b0;
  logic        record, capture_clr, kernel_valid, line_start, line_end;
  logic        frame_start, frame_end, locked, sync_err;
  logic [7:0]  kernel_index;
  logic [10:0] line_index;

  int n_cmp = 0;
  int n_bad = 0;

  logic       o_kv, o_ls, o_le, o_fs, o_fe, o_rec, o_lock, o_err, o_clr_b, o_clr_pre;
  logic [7:0] o_ki;
  logic [10:0] o_li;

  always #5 pclock = ~pclock;

  vita_capture_ctrl #(.MAX_LINES(2)) dut (
    .pclock       (pclock),
    .reset        (reset),
    .sync_bit     (sync_bit),
    .arm          (arm),
    .record       (record),
    .capture_clr  (capture_clr),
    .kernel_valid (kernel_valid),
    .line_start   (line_start),
    .line_end     (line_end),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .kernel_index (kernel_index),
    .line_index   (line_index),
    .locked       (locked),
    .sync_err     (sync_err)
  );

  // arm_mode: 0 none, 1 during the first bit, 2 during the boundary (last) bit.
  task automatic send_word(input logic [15:0] w, input int arm_mode);
    logic [4:0] strobes;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclock);
      sync_bit = w[15-i];
      arm = (arm_mode == 1 && i == 0) || (arm_mode == 2 && i == 15);
      if (i == 1) begin
        strobes = {kernel_valid, line_start, line_end, frame_start, frame_end};
        n_cmp++;
        if ({strobes, sync_err} !== 6'b0) begin
          n_bad++;
          $display("FAIL strobe_width: got %b required 000000", {strobes, sync_err});
        end
      end
      if (i == 14) o_clr_pre = capture_clr;
      if (i == 15) o_clr_b = capture_clr;
    end
    @(posedge pclock);
    #1;
    arm    = 1'b0;
    o_kv   = kernel_valid;
    o_ls   = line_start;
    o_le   = line_end;
    o_fs   = frame_start;
    o_fe   = frame_end;
    o_rec  = record;
    o_lock = locked;
    o_err  = sync_err;
    o_ki   = kernel_index;
    o_li   = line_index;
    $display("word %h arm=%0d -> kv=%b ls=%b le=%b fs=%b fe=%b rec=%b lock=%b err=%b ki=%0d li=%0d",
             w, arm_mode, o_kv, o_ls, o_le, o_fs, o_fe, o_rec, o_lock, o_err, o_ki, o_li);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclock);
      sync_bit = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge pclock);
    reset = 1'b1;
    sync_bit = 1'b0;
    arm = 1'b0;
    repeat (2) @(negedge pclock);
    reset = 1'b0;
  endtask

  task automatic do_lock();
    do_reset();
    send_bits(5);
    repeat (4) send_word(TR, 0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclock);
    #1;
    n_cmp++;
    if ({record, capture_clr, kernel_valid, line_start, line_end, frame_start, frame_end,
         locked, sync_err, kernel_index, line_index} !== 28'b0) begin
      n_bad++;
      $display("FAIL reset_state: got nonzero outputs required all 0");
    end
    $display("reset state sampled");
  endtask

  task automatic test_lock();
    reset = 1'b0;
    send_bits(5);
    send_word(TR, 0);
    send_word(TR, 0);
    send_word(TR, 0);
    n_cmp++;
    if (o_lock !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %b required 0", o_lock); end
    send_word(TR, 0);
    n_cmp++;
    if (o_lock !== 1'b1) begin n_bad++; $display("FAIL lock_4th: got %b required 1", o_lock); end
    send_word(TR, 0);
    n_cmp++;
    if (o_clr_b !== 1'b1) begin n_bad++; $display("FAIL clr_boundary: got %b required 1", o_clr_b); end
    n_cmp++;
    if (o_clr_pre !== 1'b0) begin n_bad++; $display("FAIL clr_pre: got %b required 0", o_clr_pre); end
  endtask

  task automatic test_frame();
    send_word(TR, 1);
    n_cmp++;
    if (o_fs !== 1'b0 || o_rec !== 1'b0) begin
      n_bad++; $display("FAIL arm_idle: got fs=%b rec=%b required 0 0", o_fs, o_rec);
    end
    send_word(FS, 0);
    n_cmp++;
    if ({o_fs, o_rec, o_li} !== {2'b11, 11'd0}) begin
      n_bad++; $display("FAIL frame_start: got fs=%b rec=%b li=%0d required 1 1 0", o_fs, o_rec, o_li);
    end
    send_word(LS, 0);
    n_cmp++;
    if ({o_kv, o_ls, o_rec, o_ki} !== {3'b111, 8'd0}) begin
      n_bad++; $display("FAIL line_start: got kv=%b ls=%b rec=%b ki=%0d required 1 1 1 0", o_kv, o_ls, o_rec, o_ki);
    end
    send_word(IMG, 0);
    n_cmp++;
    if ({o_kv, o_ls, o_ki} !== {2'b10, 8'd1}) begin
      n_bad++; $display("FAIL img1: got kv=%b ls=%b ki=%0d required 1 0 1", o_kv, o_ls, o_ki);
    end
    send_word(IMG, 0);
    n_cmp++;
    if ({o_kv, o_ki} !== {1'b1, 8'd2}) begin
      n_bad++; $display("FAIL img2: got kv=%b ki=%0d required 1 2", o_kv, o_ki);
    end
    send_word(LE, 0);
    n_cmp++;
    if ({o_kv, o_le, o_ki, o_li} !== {2'b11, 8'd3, 11'd0}) begin
      n_bad++; $display("FAIL line_end: got kv=%b le=%b ki=%0d li=%0d required 1 1 3 0", o_kv, o_le, o_ki, o_li);
    end
    send_word(FE, 0);
    n_cmp++;
    if ({o_fe, o_rec, o_kv, o_li} !== {3'b100, 11'd1}) begin
      n_bad++; $display("FAIL frame_end: got fe=%b rec=%b kv=%b li=%0d required 1 0 0 1", o_fe, o_rec, o_kv, o_li);
    end
  endtask

  task automatic test_fs_no_arm();
    send_word(FS, 0);
    n_cmp++;
    if (o_fs !== 1'b0 || o_rec !== 1'b0) begin
      n_bad++; $display("FAIL fs_no_arm: got fs=%b rec=%b required 0 0", o_fs, o_rec);
    end
    send_word(TR, 0);
    send_word(FS, 2);
    n_cmp++;
    if (o_fs !== 1'b1 || o_rec !== 1'b1) begin
      n_bad++; $display("FAIL fs_arm_same_cycle: got fs=%b rec=%b required 1 1", o_fs, o_rec);
    end
    send_word(FE, 0);
    n_cmp++;
    if (o_fe !== 1'b1 || o_rec !== 1'b0) begin
      n_bad++; $display("FAIL fe_after_arm: got fe=%b rec=%b required 1 0", o_fe, o_rec);
    end
  endtask

  task automatic test_errors();
    send_word(TR, 1);
    send_word(FS, 0);
    send_word(IMG, 0);
    n_cmp++;
    if (o_err !== 1'b1 || o_kv !== 1'b0) begin
      n_bad++; $display("FAIL img_before_ls: got err=%b kv=%b required 1 0", o_err, o_kv);
    end
    send_word(BAD, 0);
    n_cmp++;
    if ({o_err, o_lock, o_rec} !== 3'b100) begin
      n_bad++; $display("FAIL bad_code: got err=%b lock=%b rec=%b required 1 0 0", o_err, o_lock, o_rec);
    end
  endtask

  task automatic test_max_lines();
    do_lock();
    send_word(TR, 1);
    send_word(FS, 0);
    send_word(LS, 0);
    send_word(LE, 0);
    n_cmp++;
    if ({o_le, o_fe, o_err, o_li} !== {3'b100, 11'd0}) begin
      n_bad++; $display("FAIL line1_end: got le=%b fe=%b err=%b li=%0d required 1 0 0 0", o_le, o_fe, o_err, o_li);
    end
    send_word(LS, 0);
    n_cmp++;
    if (o_ls !== 1'b1 || o_li !== 11'd1) begin
      n_bad++; $display("FAIL line2_start: got ls=%b li=%0d required 1 1", o_ls, o_li);
    end
    send_word(IMG, 0);
    send_word(LE, 0);
    n_cmp++;
    if ({o_le, o_fe, o_err, o_rec} !== 4'b1110) begin
      n_bad++; $display("FAIL forced_end: got le=%b fe=%b err=%b rec=%b required 1 1 1 0", o_le, o_fe, o_err, o_rec);
    end
    send_word(LS, 0);
    n_cmp++;
    if (o_ls !== 1'b0 || o_kv !== 1'b0) begin
      n_bad++; $display("FAIL line3_ignored: got ls=%b kv=%b required 0 0", o_ls, o_kv);
    end
  endtask

  task automatic test_reset_mid_line();
    send_word(TR, 1);
    send_word(FS, 0);
    send_word(LS, 0);
    send_word(IMG, 0);
    n_cmp++;
    if ({o_rec, o_lock, o_ki} !== {2'b11, 8'd1}) begin
      n_bad++; $display("FAIL pre_reset: got rec=%b lock=%b ki=%0d required 1 1 1", o_rec, o_lock, o_ki);
    end
    send_bits(7);
    @(negedge pclock);
    reset = 1'b1;
    @(posedge pclock);
    #1;
    n_cmp++;
    if ({record, capture_clr, kernel_valid, line_start, line_end, frame_start, frame_end,
         locked, sync_err, kernel_index, line_index} !== 28'b0) begin
      n_bad++;
      $display("FAIL reset_mid_line: got rec=%b lock=%b ki=%0d li=%0d required all 0",
               record, locked, kernel_index, line_index);
    end
    $display("reset mid-line sampled");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_frame();
    test_fs_no_arm();
    test_errors();
    test_max_lines();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vita_capture_ctrl.md
Name: vita_capture_ctrl

Overview:
- Sequencer for the VITA2000 pixel capture datapath.
- Deserializes and word-aligns the sensor sync lane, then decodes one 16-bit sync code per kernel (16 pclock cycles, 8 pixels).
- Drives the capture block's record_in and reset so its internal bit phase is zero at each kernel start.
- Emits kernel/line/frame strobes and indices that qualify the 64-bit pixel word for downstream buffering.

Parameters:
- TR_CODE, 16'h3A6C, training word used for alignment and lock
- FS_CODE, 16'hAA00, frame start
- LS_CODE, 16'hA500, line start (first kernel of line)
- IMG_CODE, 16'h3500, image kernel
- LE_CODE, 16'hA600, line end (last kernel of line)
- FE_CODE, 16'hAB00, frame end
- LOCK_COUNT, 4, consecutive aligned TR words required to lock
- MAX_LINES, 1088, line limit before forced frame end

Ports:
- pclock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- sync_bit  in  1  sync lane, one bit per cycle, MSB first, aligned with the data lanes
- arm  in  1  one-cycle request to capture the next frame
- record  out  1  to capture record_in
- capture_clr  out  1  to capture reset
- kernel_valid  out  1  pixels word holds a complete image kernel this cycle
- line_start  out  1  pulse
- line_end  out  1  pulse
- frame_start  out  1  pulse
- frame_end  out  1  pulse
- kernel_index  out  8  kernel position within line
- line_index  out  11  line position within frame
- locked  out  1  word alignment achieved
- sync_err  out  1  one-cycle protocol error pulse

Behaviour:
- Interface: reset reset, synchronous, active-high; clock pclock. All outputs are registered and reset to 0. Reset state is HUNT; reset mid-frame aborts immediately.
- Word path:
  - sr shifts {sr[14:0],sync_bit} every cycle.
  - word = {sr[14:0],sync_bit}.
  - A 4-bit phase counter defines the boundary cycle as phase==15. Codes are evaluated only at boundary cycles, except in HUNT.
- States:
  - HUNT (locked=0): word==TR_CODE on any cycle -> phase:=0, tr_cnt:=1, go LOCKING.
  - LOCKING: at each boundary, TR -> tr_cnt++; reaching LOCK_COUNT -> LOCKED, locked=1. Any other word -> HUNT.
  - LOCKED: idle. A latched arm plus FS at a boundary -> frame_start pulse next cycle, line_index:=0, clear arm latch, go IN_FRAME. FS without arm is ignored.
  - IN_FRAME, at each boundary:
    - LS: line_start and kernel_valid pulse, kernel_index:=0.
    - IMG: kernel_valid, kernel_index+1, saturating at 255.
    - LE: kernel_valid, line_end, then line_index+1.
    - FE: frame_end, go LOCKED.
    - TR: blanking, no pulse.
- Arm: the latch sets on an arm pulse in any state, including IN_FRAME, where it applies to the next frame. Cleared by reset and on frame start.
- Strobe timing: every strobe is asserted in the cycle after the boundary, when the capture pixels register holds that kernel.
- capture_clr: registered high during every boundary cycle while state != IN_FRAME. This forces capture bin phase 0 on the first bit of the next kernel.
- record:
  - Rises in the cycle after the FS boundary.
  - Stays high throughout IN_FRAME.
  - Falls in the cycle after the FE boundary, or on any abort.
- Errors (sync_err is one-cycle):
  - IMG or LE before any LS in the current line -> sync_err; kernel dropped, no kernel_valid.
  - FS in IN_FRAME -> sync_err; frame restarts with frame_start, line_index:=0.
  - Word not equal to any of the six codes at a boundary while LOCKED or IN_FRAME -> sync_err, locked=0, record=0, HUNT.
  - line_index reaching MAX_LINES with no FE -> sync_err plus frame_end, go LOCKED.
- Simultaneity: arm on the FS boundary cycle counts for that frame.

Decomposition:
- Package vita_sync_pkg:
  - sync code constants
  - state enum (HUNT, LOCKING, LOCKED, IN_FRAME)
  - KERNEL_CYCLES=16
  - index widths
- Sub-module vita_word_aligner: shift register, phase counter, HUNT/LOCKING logic. Outputs word, boundary, locked, and a lost input to force HUNT.
- Top: frame FSM, counters, strobes.

Test Plan:
- Reset, then TR_CODE stream at bit offset 5, 4 words -> locked=1 on the cycle after the 4th boundary; capture_clr high on each boundary thereafter.
- Locked, arm, FS, LS, IMG x2, LE, FE -> frame_start, record rises next cycle, kernel_valid x4 with kernel_index 0,1,2,3, line_end, line_index=1, frame_end, record=0.
- FS without arm -> no frame_start, record stays 0. Arm asserted on the FS boundary cycle -> frame starts.
- IMG before LS in frame -> sync_err pulse, no kernel_valid. Word 16'h1234 at a boundary -> sync_err, locked=0, record=0.
- MAX_LINES overridden to 2, three LS..LE lines with no FE -> forced frame_end plus sync_err after line 2. Reset mid-line -> all outputs 0 next cycle.
